// File: rtl/fifo_v3.sv
// Single-clock FIFO with optional fall-through and DEPTH=0 pass-through.
// Holds AXI IDs/metadata in order; full/empty/usage report fill state.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    localparam bit                    PASS       = (DEPTH == 0);
    localparam int unsigned           FIFO_DEPTH = (DEPTH > 0) ? DEPTH : 1;
    localparam logic [ADDR_DEPTH-1:0] LAST_PTR   = ADDR_DEPTH'(FIFO_DEPTH - 1);
    localparam logic [ADDR_DEPTH:0]   FULL_CNT   = (ADDR_DEPTH + 1)'(FIFO_DEPTH);

    logic [ADDR_DEPTH-1:0] read_pointer_q, read_pointer_d;
    logic [ADDR_DEPTH-1:0] write_pointer_q, write_pointer_d;
    logic [ADDR_DEPTH:0]   status_cnt_q, status_cnt_d;
    dtype                  mem_q [FIFO_DEPTH];
    dtype                  mem_d [FIFO_DEPTH];
    logic                  push_ok, pop_ok;

    logic unused_testmode;
    assign unused_testmode = testmode_i;

    always_comb begin
        if (PASS) begin
            full_o  = ~pop_i;
            empty_o = ~push_i;
        end else begin
            full_o  = (status_cnt_q == FULL_CNT);
            empty_o = (status_cnt_q == '0) & ~(FALL_THROUGH & push_i);
        end
    end

    assign usage_o = status_cnt_q[ADDR_DEPTH-1:0];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        read_pointer_d  = read_pointer_q;
        write_pointer_d = write_pointer_q;
        status_cnt_d    = status_cnt_q;
        mem_d           = mem_q;
        data_o          = PASS ? data_i : mem_q[read_pointer_q];

        if (push_ok) begin
            mem_d[write_pointer_q] = data_i;
            write_pointer_d = (write_pointer_q == LAST_PTR) ? '0 : write_pointer_q + 1'b1;
        end
        if (pop_ok) begin
            read_pointer_d = (read_pointer_q == LAST_PTR) ? '0 : read_pointer_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            status_cnt_d = status_cnt_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            status_cnt_d = status_cnt_q - 1'b1;
        end

        // Fall-through on empty: present the input directly; a same-cycle pop
        // consumes it without touching storage.
        if (FALL_THROUGH && status_cnt_q == '0 && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                read_pointer_d  = read_pointer_q;
                write_pointer_d = write_pointer_q;
                status_cnt_d    = status_cnt_q;
                mem_d           = mem_q;
            end
        end

        // Flush wins over push/pop; memory keeps its stale contents.
        if (flush_i || PASS) begin
            read_pointer_d  = '0;
            write_pointer_d = '0;
            status_cnt_d    = '0;
            mem_d           = mem_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_pointer_q  <= '0;
            write_pointer_q <= '0;
            status_cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            read_pointer_q  <= read_pointer_d;
            write_pointer_q <= write_pointer_d;
            status_cnt_q    <= status_cnt_d;
            mem_q           <= mem_d;
        end
    end

`ifndef SYNTHESIS
    if (!PASS) begin : g_checks
        // Overflow/underflow are legal (silently ignored) but usually a user bug.
        assert property (@(posedge clk_i) disable iff (!rst_ni) !(full_o && push_i))
            else $warning("fifo_v3: push while full ignored");
        assert property (@(posedge clk_i) disable iff (!rst_ni) !(empty_o && pop_i))
            else $warning("fifo_v3: pop while empty ignored");
    end
`endif

endmodule

// File: tb/tb_fifo_v3.sv
// Directed bench: vector table on a DEPTH=4 FIFO, plus hand sequences for
// fall-through, pass-through and asynchronous reset.
module tb_fifo_v3;

    typedef struct {
        logic       flush, push, pop;
        logic [7:0] din;
        logic       e_empty, e_full;
        logic [1:0] e_usage;
        logic       chk_data;
        logic [7:0] e_data;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0, push = 1'b0, pop = 1'b0;
    logic [7:0] din = '0;

    logic       a_full, a_empty, b_full, b_empty, c_full, c_empty;
    logic [1:0] a_usage, b_usage;
    logic [0:0] c_usage;
    logic [7:0] a_data, b_data, c_data;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(1'b0),
        .full_o(a_full), .empty_o(a_empty), .usage_o(a_usage),
        .data_i(din), .push_i(push), .data_o(a_data), .pop_i(pop));

    fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(1'b0),
        .full_o(b_full), .empty_o(b_empty), .usage_o(b_usage),
        .data_i(din), .push_i(push), .data_o(b_data), .pop_i(pop));

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(1'b0),
        .full_o(c_full), .empty_o(c_empty), .usage_o(c_usage),
        .data_i(din), .push_i(push), .data_o(c_data), .pop_i(pop));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic fl, input logic pu, input logic po,
                                input logic [7:0] d, input logic ee, input logic ef,
                                input logic [1:0] eu, input logic cd, input logic [7:0] ed);
        vec_t v;
        v.name = name; v.flush = fl; v.push = pu; v.pop = po; v.din = d;
        v.e_empty = ee; v.e_full = ef; v.e_usage = eu; v.chk_data = cd; v.e_data = ed;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 2ns later.
    task automatic drive(input logic fl, input logic pu, input logic po, input logic [7:0] d);
        @(negedge clk);
        flush = fl; push = pu; pop = po; din = d;
        #2;
    endtask

    initial begin
        // Pre-edge view of DEPTH=4 non-fall-through FIFO for each vector.
        vecs.push_back(mk("reset_idle", 0, 0, 0, 8'h00, 1, 0, 2'd0, 1, 8'h00));
        vecs.push_back(mk("push11",     0, 1, 0, 8'h11, 1, 0, 2'd0, 0, 8'h00));
        vecs.push_back(mk("push22",     0, 1, 0, 8'h22, 0, 0, 2'd1, 1, 8'h11));
        vecs.push_back(mk("push33",     0, 1, 0, 8'h33, 0, 0, 2'd2, 1, 8'h11));
        vecs.push_back(mk("push44",     0, 1, 0, 8'h44, 0, 0, 2'd3, 1, 8'h11));
        vecs.push_back(mk("full_wrap",  0, 0, 0, 8'h00, 0, 1, 2'd0, 1, 8'h11));
        vecs.push_back(mk("full_pp55",  0, 1, 1, 8'h55, 0, 1, 2'd0, 1, 8'h11));
        vecs.push_back(mk("pop22",      0, 0, 1, 8'h00, 0, 0, 2'd3, 1, 8'h22));
        vecs.push_back(mk("pop33",      0, 0, 1, 8'h00, 0, 0, 2'd2, 1, 8'h33));
        vecs.push_back(mk("pop44",      0, 0, 1, 8'h00, 0, 0, 2'd1, 1, 8'h44));
        vecs.push_back(mk("drained",    0, 0, 0, 8'h00, 1, 0, 2'd0, 0, 8'h00));
        vecs.push_back(mk("pop_empty",  0, 0, 1, 8'h00, 1, 0, 2'd0, 0, 8'h00));
        vecs.push_back(mk("after_pope", 0, 0, 0, 8'h00, 1, 0, 2'd0, 0, 8'h00));
        vecs.push_back(mk("push01",     0, 1, 0, 8'h01, 1, 0, 2'd0, 0, 8'h00));
        vecs.push_back(mk("push02",     0, 1, 0, 8'h02, 0, 0, 2'd1, 1, 8'h01));
        // Steady push+pop at count 2 across pointer wrap: head is k+1.
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk("steady_pp", 0, 1, 1, 8'(k + 3), 0, 0, 2'd2, 1, 8'(k + 1)));
        vecs.push_back(mk("push0d",     0, 1, 0, 8'h0D, 0, 0, 2'd2, 1, 8'h0B));
        vecs.push_back(mk("flush_push", 1, 1, 0, 8'h0E, 0, 0, 2'd3, 1, 8'h0B));
        vecs.push_back(mk("post_flush", 0, 0, 0, 8'h00, 1, 0, 2'd0, 0, 8'h00));
        vecs.push_back(mk("push0f",     0, 1, 0, 8'h0F, 1, 0, 2'd0, 0, 8'h00));
        vecs.push_back(mk("ptr_zero",   0, 0, 0, 8'h00, 0, 0, 2'd1, 1, 8'h0F));
        vecs.push_back(mk("pop0f",      0, 0, 1, 8'h00, 0, 0, 2'd1, 1, 8'h0F));
        vecs.push_back(mk("nft_pp3c",   0, 1, 1, 8'h3C, 1, 0, 2'd0, 0, 8'h00));
        vecs.push_back(mk("nft_next",   0, 0, 0, 8'h00, 0, 0, 2'd1, 1, 8'h3C));
        vecs.push_back(mk("pop3c",      0, 0, 1, 8'h00, 0, 0, 2'd1, 1, 8'h3C));
        vecs.push_back(mk("flush_all",  1, 0, 0, 8'h00, 1, 0, 2'd0, 0, 8'h00));

        // Reset asserted at time 0; outputs must already be at reset values.
        #2;
        chk("rst_a_empty", a_empty, 1);
        chk("rst_a_data",  a_data,  8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].push, vecs[i].pop, vecs[i].din);
            chk({vecs[i].name, "_empty"}, a_empty, vecs[i].e_empty);
            chk({vecs[i].name, "_full"},  a_full,  vecs[i].e_full);
            chk({vecs[i].name, "_usage"}, a_usage, vecs[i].e_usage);
            if (vecs[i].chk_data) chk({vecs[i].name, "_data"}, a_data, vecs[i].e_data);
        end

        // Fall-through (b) and pass-through (c); both FIFOs flushed above.
        drive(0, 1, 1, 8'hA5);
        chk("ft_bypass_data",  b_data,  8'hA5);
        chk("ft_bypass_empty", b_empty, 0);
        chk("ft_bypass_usage", b_usage, 0);
        chk("nft_same_empty",  a_empty, 1);
        chk("pt_data",  c_data,  8'hA5);
        chk("pt_empty", c_empty, 0);
        chk("pt_full",  c_full,  0);
        drive(0, 0, 0, 8'h00);
        chk("ft_after_usage", b_usage, 0);
        chk("ft_after_empty", b_empty, 1);
        chk("nft_stored_usage", a_usage, 1);
        chk("nft_stored_data",  a_data,  8'hA5);
        chk("pt_idle_empty", c_empty, 1);
        chk("pt_idle_full",  c_full,  1);
        drive(0, 1, 0, 8'h77);
        chk("ft_push_data",  b_data,  8'h77);
        chk("ft_push_empty", b_empty, 0);
        chk("ft_push_usage", b_usage, 0);
        drive(0, 0, 0, 8'h00);
        chk("ft_stored_usage", b_usage, 1);
        chk("ft_stored_data",  b_data,  8'h77);
        chk("ft_stored_empty", b_empty, 0);

        // Mid-cycle asynchronous reset with data present in both FIFOs.
        drive(0, 1, 0, 8'h99);
        drive(0, 0, 0, 8'h00);
        chk("pre_rst_usage", a_usage, 3);
        rst_n = 1'b0;
        #1;
        chk("arst_a_empty", a_empty, 1);
        chk("arst_a_full",  a_full,  0);
        chk("arst_a_usage", a_usage, 0);
        chk("arst_a_data",  a_data,  8'h00);
        chk("arst_b_usage", b_usage, 0);
        chk("arst_b_data",  b_data,  8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 8'h00);
        chk("post_rst_empty", a_empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
